reg_writeback_seq: RTL and testbench

//  Write side of the CPU register interface: turns ALU/datapath results into the

---
 rtl/cpu_wb_pkg.sv | 27 ++
 rtl/wb_fifo.sv | 49 ++++
 rtl/reg_writeback_seq.sv | 80 ++++++++
 tb/tb_reg_writeback_seq.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/cpu_wb_pkg.sv
// rtl/cpu_wb_pkg.sv - destination codes and strobe decode shared by the register writeback path
package cpu_wb_pkg;

  localparam int DST_W          = 2;
  localparam int DATA_W_DEFAULT = 16;

  typedef enum logic [DST_W-1:0] {
    DST_A    = 2'd0,
    DST_B    = 2'd1,
    DST_AB   = 2'd2,
    DST_NONE = 2'd3
  } dst_e;

  // Returns {load_a, load_b} for a destination code.
  function automatic logic [1:0] dst_loads(input logic [DST_W-1:0] dst);
    logic [1:0] loads;
    loads = 2'b00;
    case (dst)
      DST_A:   loads = 2'b10;
      DST_B:   loads = 2'b01;
      DST_AB:  loads = 2'b11;
      default: loads = 2'b00;
    endcase
    return loads;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - synchronous FIFO with flush and occupancy level for the writeback queue
module wb_fifo #(
  parameter int W     = 18,
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [W-1:0]     push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [W-1:0]     head_data,
  output logic [CNT_W-1:0] level
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // Storage is not reset; callers never push during reset or flush.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // DEPTH is a power of two, so pointers wrap naturally at AW bits.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  assign head_data = mem[rd_ptr];

endmodule

// File: rtl/reg_writeback_seq.sv
// rtl/reg_writeback_seq.sv - buffered register writeback sequencer; WB_BYPASS_EN enables empty-queue bypass
module reg_writeback_seq
  import cpu_wb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              res_valid,
  output logic              res_ready,
  input  logic [DATA_W-1:0] res_data,
  input  logic [DST_W-1:0]  res_dst,
  input  logic              stall,
  input  logic              flush,
  output logic              load_a,
  output logic              load_b,
  output logic [DATA_W-1:0] data_out,
  output logic [CNT_W-1:0]  level
);

  localparam int EW = DST_W + DATA_W;

  logic              accept;
  logic              pop;
  logic              bypass;
  logic              fifo_push;
  logic [EW-1:0]     head;
  logic [DST_W-1:0]  head_dst;
  logic [DATA_W-1:0] head_data;

  assign res_ready = rst_n && (level != CNT_W'(DEPTH));
  // A result offered during flush is acknowledged but dropped.
  assign accept    = res_valid && res_ready && !flush;
  assign pop       = (level != '0) && !stall && !flush;

`ifdef WB_BYPASS_EN
  assign bypass    = accept && (level == '0) && !stall;
`else
  assign bypass    = 1'b0;
`endif

  assign fifo_push = accept && !bypass;
  assign {head_dst, head_data} = head;

  wb_fifo #(
    .W     (EW),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_data ({res_dst, res_data}),
    .pop       (pop),
    .flush     (flush),
    .head_data (head),
    .level     (level)
  );

  // A discarded (NONE) entry still consumes a slot but leaves data_out untouched.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      load_a   <= 1'b0;
      load_b   <= 1'b0;
      data_out <= '0;
    end else if (pop) begin
      {load_a, load_b} <= dst_loads(head_dst);
      if (head_dst != DST_NONE) data_out <= head_data;
    end else if (bypass) begin
      {load_a, load_b} <= dst_loads(res_dst);
      if (res_dst != DST_NONE) data_out <= res_data;
    end else begin
      load_a <= 1'b0;
      load_b <= 1'b0;
    end
  end

endmodule

// File: tb/tb_reg_writeback_seq.sv
// tb/tb_reg_writeback_seq.sv - scoreboard bench for reg_writeback_seq (honours WB_BYPASS_EN)
module tb_reg_writeback_seq;
  import cpu_wb_pkg::*;

  localparam int DW    = 16;
  localparam int DEPTH = 4;
  localparam int CNT_W = 3;
`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n, res_valid, res_ready, stall, flush, load_a, load_b;
  logic [1:0]       res_dst;
  logic [DW-1:0]    res_data, data_out;
  logic [CNT_W-1:0] level;

  int errors = 0;
  int checks = 0;
  int m_level = 0;
  int n_strobe = 0;
  int base;
  logic [17:0] sb [$];

  always #5 clk = ~clk;

  reg_writeback_seq #(.DATA_W(DW), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_dst   (res_dst),
    .stall     (stall),
    .flush     (flush),
    .load_a    (load_a),
    .load_b    (load_b),
    .data_out  (data_out),
    .level     (level)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives one cycle, updates the reference level and scoreboard, then checks after the edge.
  task automatic step(input logic r, input logic v, input logic [1:0] d,
                      input logic [15:0] x, input logic s, input logic f);
    logic exp_ready, push, pop, byp;
    logic [17:0] e;
    rst_n = r; res_valid = v; res_dst = d; res_data = x; stall = s; flush = f;
    #1;
    exp_ready = r && (m_level != DEPTH);
    chk("res_ready", 32'(res_ready), 32'(exp_ready));
    push = v && exp_ready && !f;
    pop  = (m_level != 0) && !s && !f;
    byp  = BYP && push && (m_level == 0) && !s;
    if (!r || f) begin
      sb.delete();
      m_level = 0;
    end else begin
      if (push && d != DST_NONE) sb.push_back({d, x});
      m_level = m_level + ((push && !byp) ? 1 : 0) - (pop ? 1 : 0);
    end
    @(posedge clk);
    @(negedge clk);
    chk("level", 32'(level), 32'(m_level));
    if (!r) begin
      chk("rst_load_a", 32'(load_a), 32'(0));
      chk("rst_load_b", 32'(load_b), 32'(0));
      chk("rst_data_out", 32'(data_out), 32'(0));
    end
    if (load_a || load_b) begin
      n_strobe++;
      if (sb.size() == 0) begin
        chk("unexpected_strobe", 32'({load_a, load_b}), 32'(0));
      end else begin
        e = sb.pop_front();
        chk("strobe", 32'({load_a, load_b, data_out}), 32'({dst_loads(e[17:16]), e[15:0]}));
      end
    end
  endtask

  task automatic idle();
    step(1'b1, 1'b0, DST_A, 16'h0000, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; res_valid = 1'b0; res_dst = DST_A; res_data = '0; stall = 1'b0; flush = 1'b0;

    step(1'b0, 1'b0, DST_A, 16'h0000, 1'b0, 1'b0);
    step(1'b0, 1'b0, DST_A, 16'h0000, 1'b0, 1'b0);

    // single write to A: latency and one-cycle strobe
    step(1'b1, 1'b1, DST_A, 16'h1234, 1'b0, 1'b0);
    chk("t1_strobe_edge1", 32'(load_a), 32'(BYP));
    idle();
    chk("t1_strobe_edge2", 32'(load_a), 32'(!BYP));
    idle();
    chk("t1_one_cycle", 32'(load_a), 32'(0));
    chk("t1_data", 32'(data_out), 32'h1234);

    // fill under stall, fifth offer refused, then drain back-to-back
    for (int i = 0; i < 5; i++)
      step(1'b1, 1'b1, (i % 2 == 1) ? DST_B : DST_A, 16'(16'h0100 + i), 1'b1, 1'b0);
    chk("t2_full_level", 32'(level), 32'(4));
    chk("t2_full_ready", 32'(res_ready), 32'(0));
    base = n_strobe;
    for (int i = 0; i < 4; i++) begin
      idle();
      chk("t2_consecutive", 32'(load_a | load_b), 32'(1));
    end
    idle();
    chk("t2_strobe_count", 32'(n_strobe - base), 32'(4));

    // A+B write then a discarded result
    base = n_strobe;
    step(1'b1, 1'b1, DST_AB, 16'hBEEF, 1'b0, 1'b0);
    step(1'b1, 1'b1, DST_NONE, 16'h0001, 1'b0, 1'b0);
    idle(); idle(); idle();
    chk("t3_strobe_count", 32'(n_strobe - base), 32'(1));
    chk("t3_data_hold", 32'(data_out), 32'hBEEF);
    chk("t3_quiet", 32'({load_a, load_b}), 32'(0));

    // flush at level 3 drops the queue and the concurrent offer
    for (int i = 0; i < 3; i++)
      step(1'b1, 1'b1, DST_A, 16'(16'h0300 + i), 1'b1, 1'b0);
    chk("t4_level3", 32'(level), 32'(3));
    step(1'b1, 1'b1, DST_B, 16'hDEAD, 1'b1, 1'b1);
    chk("t4_level0", 32'(level), 32'(0));
    base = n_strobe;
    idle(); idle(); idle(); idle();
    chk("t4_no_strobes", 32'(n_strobe - base), 32'(0));
    chk("t4_data_hold", 32'(data_out), 32'hBEEF);

    // continuous stream wraps pointers
    base = n_strobe;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b1, (i % 3 == 0) ? DST_A : ((i % 3 == 1) ? DST_B : DST_AB),
           16'(16'h2000 + i), 1'b0, 1'b0);
      chk("t5_level_le1", 32'(level <= 3'd1), 32'(1));
    end
    idle(); idle();
    chk("t5_strobe_count", 32'(n_strobe - base), 32'(10));
    chk("t5_sb_empty", 32'(sb.size()), 32'(0));

    // reset with entries buffered
    step(1'b1, 1'b1, DST_A, 16'h6000, 1'b1, 1'b0);
    step(1'b1, 1'b1, DST_B, 16'h6001, 1'b1, 1'b0);
    chk("t6_level2", 32'(level), 32'(2));
    step(1'b0, 1'b1, DST_A, 16'h7777, 1'b0, 1'b0);
    step(1'b0, 1'b0, DST_A, 16'h0000, 1'b0, 1'b0);
    base = n_strobe;
    idle(); idle(); idle();
    chk("t6_no_stale", 32'(n_strobe - base), 32'(0));
    chk("t6_data_zero", 32'(data_out), 32'(0));
    chk("final_sb_empty", 32'(sb.size()), 32'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
